// File: rtl/instruction_line_fetcher_pkg.sv
// Shared state encoding, widths and slot helper for the instruction line fetcher.
package instruction_line_fetcher_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_W     = 64;
  localparam int BEAT_W     = 2;
  localparam int LINE_NUM_W = 6;
  localparam int MEM_ADDR_W = LINE_NUM_W + BEAT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  // Bit offset of a beat's 16-bit slot inside the assembled line.
  function automatic int beat_lsb(input logic [BEAT_W-1:0] beat);
    return int'(beat) * WORD_W;
  endfunction

endpackage

// File: rtl/instruction_line_fetcher_if.sv
// Cache-side line request and memory-side word fetch signals of the line fetcher.
interface instruction_line_fetcher_if;
  import instruction_line_fetcher_pkg::*;

  logic                  line_read_enable;
  logic [LINE_NUM_W-1:0] line_address;
  logic                  line_ready;
  logic [LINE_W-1:0]     line_data;
  logic                  mem_read_enable;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic                  mem_ack;
  logic [WORD_W-1:0]     mem_data;

  modport slave (
    input  line_read_enable, line_address, mem_ack, mem_data,
    output line_ready, line_data, mem_read_enable, mem_address
  );

  modport master (
    output line_read_enable, line_address, mem_ack, mem_data,
    input  line_ready, line_data, mem_read_enable, mem_address
  );

endinterface

// File: rtl/instruction_line_fetcher.sv
// Fills one 64-bit cache line by reading four 16-bit words in order 0..3,
// then pulses line_ready for a single cycle.
module instruction_line_fetcher
  import instruction_line_fetcher_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_W    = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_line_fetcher_if.slave bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;
  logic [BEAT_W-1:0]      r_beat;
  logic [BEAT_W-1:0]      w_beat_next;
  logic [LINE_ADDR_W-1:0] r_line;
  logic [LINE_ADDR_W-1:0] w_line_next;
  logic [LINE_W-1:0]      r_line_data;
  logic                   w_capture;

  // NOTE: the line buffer is reset along with the control state because a
  // freshly reset fetcher must present an all-zero line to the cache.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_line      <= '0;
      r_line_data <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values,
      // letting the capture below use the beat that is being retired.
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
      r_line  <= w_line_next;
      if (w_capture) begin
        r_line_data[beat_lsb(r_beat) +: WORD_W] <= bus.mem_data;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_line_next  = r_line;
    w_capture    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.line_read_enable) begin
          w_state_next = FETCH;
          w_line_next  = bus.line_address;
          w_beat_next  = '0;
        end
      end
      FETCH: begin
        // Requests arriving mid-fill are dropped; the cache retries later.
        if (bus.mem_ack) begin
          w_capture = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_next = DONE;
          end else begin
            w_beat_next = r_beat + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Every output is a direct decode of registered state.
  assign bus.line_ready      = (r_state == DONE);
  assign bus.mem_read_enable = (r_state == FETCH);
  assign bus.mem_address     = {r_line, r_beat};
  assign bus.line_data       = r_line_data;

endmodule

// File: doc/instruction_line_fetcher.md
INSTRUCTION_LINE_FETCHER -- requirements
Module: instruction_line_fetcher

Interface
REQ-001 Parameter WORDS_PER_LINE, 4, number of 16-bit beats per cache line; fixed at 4.
REQ-002 Parameter LINE_ADDR_W, 6, width of the line address from the cache.
REQ-003 Port clock, input, 1, rising-edge clock.
REQ-004 Port reset, input, 1, synchronous, active-high.
REQ-005 Port line_read_enable, input, 1, single-cycle line-fill request pulse from the cache.
REQ-006 Port line_address, input, 6, line number to fill, valid with line_read_enable.
REQ-007 Port line_ready, output, 1, one-cycle pulse; line_data is valid in this cycle.
REQ-008 Port line_data, output, 64, assembled line; word 0 in [15:0], word 3 in [63:48].
REQ-009 Port mem_read_enable, output, 1, word read request to instruction memory.
REQ-010 Port mem_address, output, 8, word address {latched line, beat[1:0]}.
REQ-011 Port mem_ack, input, 1, memory has mem_data valid for the current request.
REQ-012 Port mem_data, input, 16, returned instruction word.

Function
REQ-013 The FSM SHALL have three states: IDLE, FETCH and DONE.
REQ-014 IDLE SHALL go to FETCH on line_read_enable=1, latch line_address and clear beat to 0.
REQ-015 line_read_enable SHALL be ignored in FETCH and DONE, with no effect on the latched address or beat.
REQ-016 In FETCH, mem_read_enable SHALL be 1 and mem_address SHALL equal {latched line, beat}.
REQ-017 mem_read_enable SHALL stay high until mem_ack=1; a wait of any number of cycles is legal.
REQ-018 In FETCH with mem_ack=1, mem_data SHALL be written to line_data slot [16*beat+15:16*beat] at the clock edge.
REQ-019 mem_ack=1 in FETCH SHALL increment beat when beat<3, and go to DONE when beat=3.
REQ-020 mem_ack SHALL be ignored in IDLE and DONE.
REQ-021 In DONE, line_ready SHALL be 1 for exactly one cycle, mem_read_enable SHALL be 0, and the next state SHALL be IDLE.
REQ-022 line_data SHALL hold the last completed line until the first beat of the next fill overwrites slot 0.
REQ-023 Minimum latency (mem_ack tied high): request in cycle N; beats captured in cycles N+1..N+4; line_ready in cycle N+5.
REQ-024 Beat order SHALL be fixed 0,1,2,3, with no critical-word-first reordering.
REQ-025 The 2-bit beat counter SHALL NOT wrap outside FETCH.
REQ-026 A new request SHALL be accepted in the cycle after line_ready, giving back-to-back fills with no extra idle cycle.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, beat=0, latched line=0 and line_data=64'h0.
REQ-028 While reset=1, line_ready=0 and mem_read_enable=0.
REQ-029 Reset during FETCH SHALL abandon the fill with no line_ready pulse.
REQ-030 A mem_ack arriving after reset SHALL be ignored.
REQ-031 reset SHALL take priority over line_read_enable in the same cycle.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=2'd0, FETCH=2'd1, DONE=2'd2), WORD_W=16, LINE_W=64 and BEAT_W=2.
REQ-033 The block SHALL be a single module with no sub-module; the FSM, beat counter and line buffer are inline.
REQ-034 All outputs SHALL be driven from registered state only, with no combinational path from inputs to outputs.

Verification
REQ-035 Single fill: line_address=6'h2A, mem_ack tied 1, memory word k=16'h1000+k -> mem_address 8'hA8..8'hAB; line_ready at N+5; line_data=64'h10AB10AA10A910A8.
REQ-036 Stalled memory: mem_ack low 3 cycles per beat -> mem_read_enable and mem_address held stable while waiting; line_ready at N+17; same data as REQ-035.
REQ-037 Ignored request: line_read_enable pulsed with line_address=6'h05 during FETCH of 6'h2A -> mem_address stays 8'hA8..8'hAB; exactly one line_ready pulse.
REQ-038 Back-to-back: request 6'h01 the cycle after line_ready of 6'h00 -> mem_read_enable high the following cycle at address 8'h04.
REQ-039 Reset mid-fill: reset after beat 1 captured -> line_ready never pulses; line_data=0; next request 6'h3F fetches 8'hFC..8'hFF correctly.
REQ-040 Spurious ack: mem_ack=1 in IDLE with mem_data=16'hDEAD -> line_data unchanged; no state change.
